// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand/result bundle for seq_chunk_adder.
// The master drives the operands and out_ready; the slave is the adder.
interface seq_chunk_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock with a registered
// ripple carry, valid/ready on both sides, reports sum/cout/overflow/zero.
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic             clk,
  input logic             rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r, ovf_r, zero_r;

  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]   slice_res;
  logic [WIDTH-1:0] sum_nx;
  logic             last;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    a_slice   = a_reg[k*CHUNK +: CHUNK];
    b_slice   = b_reg[k*CHUNK +: CHUNK];
    slice_res = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
    sum_nx    = sum_r;
    sum_nx[k*CHUNK +: CHUNK] = slice_res[CHUNK-1:0];
    last      = (k == KW'(NCHUNK - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Carry into the MSB is recovered as a^b^s at that bit, so overflow needs
  // no extra per-bit carry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      k      <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          a_reg <= bus.a;
          b_reg <= bus.sub ? ~bus.b : bus.b;
          carry <= bus.sub ? ~bus.cin : bus.cin;
          k     <= '0;
        end
        BUSY: begin
          sum_r <= sum_nx;
          carry <= slice_res[CHUNK];
          k     <= k + 1'b1;
          if (last) begin
            cout_r <= slice_res[CHUNK];
            ovf_r  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ sum_nx[WIDTH-1]
                      ^ slice_res[CHUNK];
            zero_r <= ~|sum_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.overflow  = ovf_r;
  assign bus.zero      = zero_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder (WIDTH=32, CHUNK=8, latency 4).
module tb_seq_chunk_adder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_chunk_adder_if #(.WIDTH(32)) bus ();

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents operands at a negedge; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_done(input string tag, input logic [31:0] esum,
                           input logic ecout, input logic eovf, input logic ezero);
    int lat;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},  32'(lat), 32'd4);
    chk({tag, "_sum"},  bus.sum, esum);
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ecout));
    chk({tag, "_ovf"},  32'(bus.overflow), 32'(eovf));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(ezero));
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_release_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus.sub = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum",       bus.sum, 32'h0);
    chk("rst_flags", {29'd0, bus.cout, bus.overflow, bus.zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0);
    finish_op("add_ovf");

    start_op(32'h80000000, 32'h00000001, 1'b0, 1'b1);
    wait_done("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    finish_op("sub_ovf");

    start_op(32'hFFFFFFFC, 32'h00000005, 1'b0, 1'b0);
    wait_done("add_carry", 32'h00000001, 1'b1, 1'b0, 1'b0);
    finish_op("add_carry");

    start_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    wait_done("ripple", 32'h00000000, 1'b1, 1'b0, 1'b1);
    finish_op("ripple");

    start_op(32'hFFFFFC19, 32'hFFFFFC19, 1'b0, 1'b1);
    wait_done("sub_eq", 32'h00000000, 1'b1, 1'b0, 1'b1);
    finish_op("sub_eq");

    // out_ready held high while BUSY: result still appears, for exactly one cycle
    start_op(32'h0000000A, 32'h00000014, 1'b0, 1'b1);
    bus.out_ready = 1'b1;
    wait_done("sub_neg", 32'hFFFFFFF6, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("early_ready_valid", 32'(bus.out_valid), 32'd0);
    chk("early_ready_in",    32'(bus.in_ready), 32'd1);
    chk("held_sum",          bus.sum, 32'hFFFFFFF6);
    bus.out_ready = 1'b0;

    // Backpressure with the next operation already presented
    start_op(32'h00000010, 32'h00000020, 1'b0, 1'b0);
    wait_done("bp", 32'h00000030, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.a = 32'h00000065; bus.b = 32'h000003E8; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid",    32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_sum",      bus.sum, 32'h00000030);
      chk("bp_flags", {29'd0, bus.cout, bus.overflow, bus.zero}, 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_accept", 32'(bus.in_ready), 32'd0);
    wait_done("b2b", 32'h0000044D, 1'b0, 1'b0, 1'b0);
    finish_op("b2b");

    // Reset two cycles into BUSY aborts the operation
    start_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_sum",   bus.sum, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_hold_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'h000000A5, 32'h000003E8, 1'b0, 1'b0);
    wait_done("post_rst", 32'h0000048D, 1'b0, 1'b0, 1'b0);
    finish_op("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
